// File: rtl/j11_pkg.sv
// J11 memory controller shared definitions.
// State encoding, I/O page tag and default RAM ceiling.
package j11_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAM  = 2'd1,
    S_IO   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [8:0]  IOPAGE_HI  = 9'o777;
  localparam logic [21:0] RAMTOP_DEF = 22'o17760000;

endpackage

// File: rtl/j11_memctl_tmo.sv
// I/O access watchdog: loadable down-counter.
// expired is high in the last counted cycle.
module j11_memctl_tmo #(
  parameter logic [7:0] LOAD = 8'd255
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic stop,
  output logic expired
);

  logic [7:0] cnt;

  // load on start, clear on stop, else count down to zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (stop) begin
      cnt <= 8'd0;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd1);

endmodule

// File: rtl/j11_memctl.sv
// J11 memory-side stage: RAM / I/O page / NXM routing.
// Option: J11_MEMCTL_TIMEOUT_EN enables the I/O watchdog.
module j11_memctl
  import j11_pkg::*;
#(
  parameter logic [21:0] RAMTOP  = RAMTOP_DEF,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memreq,
  input  logic        memwr,
  input  logic [21:0] memaddr,
  input  logic [15:0] memwdata,
  output logic        memack,
  output logic [15:0] memrdata,
  output logic        memerr,
  output logic        ramreq,
  output logic        ramwr,
  output logic [20:0] ramaddr,
  output logic [15:0] ramwdata,
  input  logic        ramack,
  input  logic [15:0] ramrdata,
  output logic        ioreq,
  output logic        iowr,
  output logic [12:0] ioaddr,
  output logic [15:0] iowdata,
  input  logic        ioack,
  input  logic [15:0] iordata,
  input  logic        ioerr
);

  localparam logic [7:0] TMO_LD = 8'(TIMEOUT);

  state_t      state;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        is_io;
  logic        is_ram;
  logic        tmo_exp;

  assign is_io  = (memaddr[21:13] == IOPAGE_HI);
  assign is_ram = !is_io && (memaddr < RAMTOP);

`ifdef J11_MEMCTL_TIMEOUT_EN
  logic tmo_start;
  logic tmo_stop;

  assign tmo_start = (state == S_IDLE) && memreq && is_io;
  assign tmo_stop  = (state == S_IO) && ioack;

  j11_memctl_tmo #(
    .LOAD(TMO_LD)
  ) u_tmo (
    .clk    (clk),
    .rstn   (rstn),
    .start  (tmo_start),
    .stop   (tmo_stop),
    .expired(tmo_exp)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LD;
  assign tmo_exp    = 1'b0;
`endif

  // request FSM: accept, route, wait for completion, ack
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      memack   <= 1'b0;
      memrdata <= 16'd0;
      memerr   <= 1'b0;
      ramreq   <= 1'b0;
      ramwr    <= 1'b0;
      ramaddr  <= 21'd0;
      ramwdata <= 16'd0;
      ioreq    <= 1'b0;
      iowr     <= 1'b0;
      ioaddr   <= 13'd0;
      iowdata  <= 16'd0;
      rdata_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      memack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          memrdata <= 16'd0;
          memerr   <= 1'b0;
          if (memreq) begin
            ramaddr  <= memaddr[21:1];
            ramwdata <= memwdata;
            ioaddr   <= memaddr[12:0];
            iowdata  <= memwdata;
            rdata_q  <= 16'd0;
            err_q    <= 1'b0;
            unique case (1'b1)
              is_io: begin
                ioreq <= 1'b1;
                iowr  <= memwr;
                state <= S_IO;
              end
              is_ram: begin
                ramreq <= 1'b1;
                ramwr  <= memwr;
                state  <= S_RAM;
              end
              default: begin
                err_q <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
        end
        S_RAM: begin
          if (ramack) begin
            ramreq <= 1'b0;
            ramwr  <= 1'b0;
            if (!ramwr) rdata_q <= ramrdata;
            state <= S_DONE;
          end
        end
        S_IO: begin
          if (ioack) begin
            ioreq <= 1'b0;
            iowr  <= 1'b0;
            err_q <= ioerr;
            if (!iowr && !ioerr) rdata_q <= iordata;
            state <= S_DONE;
          end else if (tmo_exp) begin
            ioreq <= 1'b0;
            iowr  <= 1'b0;
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          memack   <= 1'b1;
          memrdata <= rdata_q;
          memerr   <= err_q;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j11_memctl.sv
// Directed bench for j11_memctl.
// RAMTOP lowered so 22'o17000000 decodes as NXM.
module tb_j11_memctl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        memreq;
  logic        memwr;
  logic [21:0] memaddr;
  logic [15:0] memwdata;
  logic        memack;
  logic [15:0] memrdata;
  logic        memerr;
  logic        ramreq;
  logic        ramwr;
  logic [20:0] ramaddr;
  logic [15:0] ramwdata;
  logic        ramack;
  logic [15:0] ramrdata;
  logic        ioreq;
  logic        iowr;
  logic [12:0] ioaddr;
  logic [15:0] iowdata;
  logic        ioack;
  logic [15:0] iordata;
  logic        ioerr;

  int checks = 0;
  int errors = 0;
  int ackcnt = 0;
  int a0;
  int hi;

  j11_memctl #(
    .RAMTOP (22'o17000000),
    .TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .memreq  (memreq),
    .memwr   (memwr),
    .memaddr (memaddr),
    .memwdata(memwdata),
    .memack  (memack),
    .memrdata(memrdata),
    .memerr  (memerr),
    .ramreq  (ramreq),
    .ramwr   (ramwr),
    .ramaddr (ramaddr),
    .ramwdata(ramwdata),
    .ramack  (ramack),
    .ramrdata(ramrdata),
    .ioreq   (ioreq),
    .iowr    (iowr),
    .ioaddr  (ioaddr),
    .iowdata (iowdata),
    .ioack   (ioack),
    .iordata (iordata),
    .ioerr   (ioerr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (memack === 1'b1) ackcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic issue(logic wr, logic [21:0] a, logic [15:0] d);
    memreq   = 1'b1;
    memwr    = wr;
    memaddr  = a;
    memwdata = d;
    tick();
    memreq   = 1'b0;
    memwr    = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; memreq = 1'b0; memwr = 1'b0;
    memaddr = '0; memwdata = '0;
    ramack = 1'b0; ramrdata = '0;
    ioack = 1'b0; iordata = '0; ioerr = 1'b0;
    repeat (3) tick();
    chk("rst_memack", 32'(memack), 32'd0);
    chk("rst_ramreq", 32'(ramreq), 32'd0);
    chk("rst_ioreq", 32'(ioreq), 32'd0);
    chk("rst_memrdata", 32'(memrdata), 32'd0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    rstn = 1'b1;
    tick();

    // RAM read; a stray memreq while busy must be ignored
    a0 = ackcnt;
    issue(1'b0, 22'o001000, 16'd0);
    chk("rd_ramreq", 32'(ramreq), 32'd1);
    chk("rd_ramaddr", 32'(ramaddr), 32'o000400);
    chk("rd_ramwr", 32'(ramwr), 32'd0);
    issue(1'b0, 22'o17000000, 16'd0);
    chk("rd_ramaddr_hold", 32'(ramaddr), 32'o000400);
    ramack = 1'b1; ramrdata = 16'o123456;
    tick();
    ramack = 1'b0; ramrdata = '0;
    chk("rd_ramreq_drop", 32'(ramreq), 32'd0);
    chk("rd_early_ack", 32'(memack), 32'd0);
    tick();
    chk("rd_memack", 32'(memack), 32'd1);
    chk("rd_memrdata", 32'(memrdata), 32'o123456);
    chk("rd_memerr", 32'(memerr), 32'd0);
    tick();
    chk("rd_ack_pulse", 32'(memack), 32'd0);
    repeat (4) tick();
    chk("rd_ack_count", 32'(ackcnt - a0), 32'd1);

    // RAM write
    issue(1'b1, 22'o000100, 16'o777);
    chk("wr_ramwr", 32'(ramwr), 32'd1);
    chk("wr_ramwdata", 32'(ramwdata), 32'o777);
    chk("wr_ramaddr", 32'(ramaddr), 32'o40);
    ramack = 1'b1; ramrdata = 16'hffff;
    tick();
    ramack = 1'b0;
    tick();
    chk("wr_memack", 32'(memack), 32'd1);
    chk("wr_memrdata", 32'(memrdata), 32'd0);
    chk("wr_memerr", 32'(memerr), 32'd0);
    tick();

    // I/O read rejected by device; stray ramack ignored
    issue(1'b0, 22'o17777560, 16'd0);
    chk("io_ioreq", 32'(ioreq), 32'd1);
    chk("io_ioaddr", 32'(ioaddr), 32'o17560);
    chk("io_ramreq", 32'(ramreq), 32'd0);
    ramack = 1'b1;
    tick();
    ramack = 1'b0;
    chk("io_stray_ramack", 32'(ioreq), 32'd1);
    chk("io_no_ack", 32'(memack), 32'd0);
    ioack = 1'b1; ioerr = 1'b1; iordata = 16'o1234;
    tick();
    ioack = 1'b0; ioerr = 1'b0;
    chk("io_ioreq_drop", 32'(ioreq), 32'd0);
    tick();
    chk("ioe_memack", 32'(memack), 32'd1);
    chk("ioe_memerr", 32'(memerr), 32'd1);
    chk("ioe_memrdata", 32'(memrdata), 32'd0);
    tick();

    // I/O read OK with simultaneous ramack
    issue(1'b0, 22'o17777570, 16'd0);
    ioack = 1'b1; ramack = 1'b1;
    iordata = 16'o54321; ramrdata = 16'o11111;
    tick();
    ioack = 1'b0; ramack = 1'b0;
    tick();
    chk("io_memack", 32'(memack), 32'd1);
    chk("io_memrdata", 32'(memrdata), 32'o54321);
    chk("io_memerr", 32'(memerr), 32'd0);
    tick();

    // NXM: ack two cycles after the request cycle
    issue(1'b0, 22'o17000000, 16'd0);
    chk("nxm_ramreq", 32'(ramreq), 32'd0);
    chk("nxm_ioreq", 32'(ioreq), 32'd0);
    chk("nxm_early", 32'(memack), 32'd0);
    tick();
    chk("nxm_memack", 32'(memack), 32'd1);
    chk("nxm_memerr", 32'(memerr), 32'd1);
    chk("nxm_memrdata", 32'(memrdata), 32'd0);
    tick();

`ifdef J11_MEMCTL_TIMEOUT_EN
    // I/O timeout, then a late ioack
    issue(1'b0, 22'o17777600, 16'd0);
    hi = 0;
    for (int i = 0; i < 20 && ioreq; i++) begin
      hi++;
      tick();
    end
    chk("tmo_cycles", 32'(hi), 32'd8);
    chk("tmo_pre_ack", 32'(memack), 32'd0);
    tick();
    chk("tmo_memack", 32'(memack), 32'd1);
    chk("tmo_memerr", 32'(memerr), 32'd1);
    chk("tmo_memrdata", 32'(memrdata), 32'd0);
    tick();
    a0 = ackcnt;
    ioack = 1'b1; iordata = 16'o7777;
    tick();
    ioack = 1'b0;
    repeat (4) tick();
    chk("tmo_late_ack", 32'(ackcnt - a0), 32'd0);
`else
    // without the watchdog an I/O access waits for ioack
    issue(1'b0, 22'o17777600, 16'd0);
    repeat (20) tick();
    chk("wait_ioreq", 32'(ioreq), 32'd1);
    chk("wait_no_ack", 32'(memack), 32'd0);
    ioack = 1'b1; iordata = 16'o4242;
    tick();
    ioack = 1'b0;
    tick();
    chk("wait_memack", 32'(memack), 32'd1);
    chk("wait_memrdata", 32'(memrdata), 32'o4242);
    tick();
`endif

    // reset during a RAM access
    a0 = ackcnt;
    issue(1'b0, 22'o002000, 16'd0);
    chk("ar_ramreq", 32'(ramreq), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_ramreq_drop", 32'(ramreq), 32'd0);
    ramack = 1'b1;
    tick();
    ramack = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("ar_no_ack", 32'(ackcnt - a0), 32'd0);

    // minimum-latency RAM read after reset
    issue(1'b0, 22'o002000, 16'd0);
    ramack = 1'b1; ramrdata = 16'o070707;
    tick();
    ramack = 1'b0;
    chk("lat_early", 32'(memack), 32'd0);
    tick();
    chk("lat_memack", 32'(memack), 32'd1);
    chk("lat_memrdata", 32'(memrdata), 32'o070707);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
